// File: rtl/mux_rr4.sv
// Purpose: 4-to-1 round-robin merge of valid/ready channels into one registered, source-tagged output.
// Latency: one cycle from input handshake to the word appearing on out_*.
// Backpressure: in_ready drops to zero while the output register is full and the sink stalls.
module mux_rr4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  // Output holding register: one word plus its source tag.
  typedef struct packed {
    logic             vld;
    logic [1:0]       sel;
    logic [WIDTH-1:0] dat;
  } out_reg_t;

  out_reg_t         oreg;
  logic [1:0]       ptr;       // most recently granted channel; search starts one past it
  logic             load_en;   // register is empty or drains this cycle
  logic             any_vld;
  logic [1:0]       win;       // combinational round-robin winner
  logic [1:0]       cand;
  logic             found;
  logic             xfer;
  logic [WIDTH-1:0] win_dat;

  assign load_en = !oreg.vld || out_ready;
  assign any_vld = |in_valid;

  // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself; first valid channel wins.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && in_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Grant is one-hot on the winner only when a word can actually be taken; held off during reset.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_en && any_vld) begin
      in_ready[win] = 1'b1;
    end
  end

  // in_ready is only ever set on a valid channel, so any grant is a transfer.
  assign xfer    = |(in_valid & in_ready);
  assign win_dat = in_data[win*WIDTH +: WIDTH];

  // Output register and priority pointer; pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      oreg <= '0;
      ptr  <= 2'd3;
    end else if (xfer) begin
      oreg.vld <= 1'b1;
      oreg.sel <= win;
      oreg.dat <= win_dat;
      ptr      <= win;
    end else if (oreg.vld && out_ready) begin
      // Drain without refill: data and tag keep their last values.
      oreg.vld <= 1'b0;
    end
  end

  assign out_valid = oreg.vld;
  assign out_sel   = oreg.sel;
  assign out_data  = oreg.dat;

endmodule
